// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory port between instruction fetch and data
// access. Data wins by default, and fetch is forced through after STARVE_MAX denials.
module mem_port_arbiter #(
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4,
    parameter int AW         = 64,
    parameter int DW         = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prg_req,
    input  logic [AW-1:0] prg_addr,
    output logic          prg_grant,
    output logic [DW-1:0] prg_q,
    output logic          prg_valid,
    input  logic          dat_req,
    input  logic          dat_we,
    input  logic [AW-1:0] dat_addr,
    input  logic [DW-1:0] dat_write,
    output logic          dat_grant,
    output logic [DW-1:0] dat_q,
    output logic          dat_valid,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_write,
    input  logic [DW-1:0] mem_q,
    output logic          starved
);

    logic [3:0] starve_cnt;
    // Stage 0 lines up with mem_req; stage LAT lines up with mem_q.
    logic [LAT:0] tag_v;
    logic [LAT:0] tag_f;
    logic         rd_issue;

    always_comb begin
        starved   = prg_req && (starve_cnt == 4'(STARVE_MAX));
        prg_grant = prg_req && (!dat_req || starved);
        dat_grant = dat_req && !prg_grant;
        rd_issue  = prg_grant || (dat_grant && !dat_we);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_write  <= '0;
            tag_v      <= '0;
            tag_f      <= '0;
        end else begin
            if (!prg_req || prg_grant)
                starve_cnt <= '0;
            else if (starve_cnt != 4'(STARVE_MAX))
                starve_cnt <= starve_cnt + 4'd1;

            mem_req <= prg_grant || dat_grant;
            mem_we  <= dat_grant && dat_we;
            if (prg_grant) begin
                mem_addr <= prg_addr;
            end else if (dat_grant) begin
                mem_addr  <= dat_addr;
                mem_write <= dat_write;
            end

            tag_v <= {tag_v[LAT-1:0], rd_issue};
            tag_f <= {tag_f[LAT-1:0], prg_grant};
        end
    end

    assign prg_valid = tag_v[LAT] && tag_f[LAT];
    assign dat_valid = tag_v[LAT] && !tag_f[LAT];
    assign prg_q     = mem_q;
    assign dat_q     = mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a grant/starvation model, a behavioural
// fixed-latency memory, and an in-order return queue.
module tb_mem_port_arbiter;

    localparam int LAT        = 2;
    localparam int STARVE_MAX = 4;
    localparam int AW         = 64;
    localparam int DW         = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          prg_req, dat_req, dat_we;
    logic [AW-1:0] prg_addr, dat_addr;
    logic [DW-1:0] dat_write;
    logic          prg_grant, dat_grant, prg_valid, dat_valid;
    logic [DW-1:0] prg_q, dat_q;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_write;
    logic [DW-1:0] mem_q = '0;
    logic          starved;

    mem_port_arbiter #(
        .LAT(LAT), .STARVE_MAX(STARVE_MAX), .AW(AW), .DW(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .prg_req(prg_req), .prg_addr(prg_addr), .prg_grant(prg_grant),
        .prg_q(prg_q), .prg_valid(prg_valid),
        .dat_req(dat_req), .dat_we(dat_we), .dat_addr(dat_addr),
        .dat_write(dat_write), .dat_grant(dat_grant), .dat_q(dat_q),
        .dat_valid(dat_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write(mem_write), .mem_q(mem_q), .starved(starved)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          f;
        logic [AW-1:0] addr;
        int            cyc;
    } exp_t;

    typedef struct {
        logic          v;
        logic [AW-1:0] a;
    } mrd_t;

    exp_t          sb[$];
    mrd_t          mq[$];
    exp_t          mon_e;
    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            m_cnt = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_write = '0;
    logic          g_pg = 1'b0;
    logic          g_dg = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return {a[31:0], a[63:32]} ^ 64'hC3C3_0000_5A5A_1234;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: a read presented on mem_* in cycle c returns its word in cycle c+LAT.
    always @(negedge clk) begin
        mq.push_back('{mem_req & ~mem_we, mem_addr});
        if (mq.size() > LAT) void'(mq.pop_front());
    end

    always @(posedge clk) begin
        #1;
        if (mq.size() == LAT && mq[0].v) mem_q = mem_val(mq[0].a);
        else mem_q = {$urandom, $urandom};
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("both_valid", 64'(prg_valid & dat_valid), 64'd0);
            if (prg_valid || dat_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 64'({prg_valid, dat_valid}), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ret_is_fetch", 64'(prg_valid), 64'(mon_e.f));
                    chk("ret_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("ret_data", mon_e.f ? prg_q : dat_q, mem_val(mon_e.addr));
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                chk("missing_valid", 64'(prg_valid | dat_valid), 64'd1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic drive(input logic preq, input logic [AW-1:0] paddr,
                         input logic dreq, input logic dwe,
                         input logic [AW-1:0] daddr, input logic [DW-1:0] dwrite);
        logic e_st, e_pg, e_dg;
        prg_req   = preq;
        prg_addr  = paddr;
        dat_req   = dreq;
        dat_we    = dwe;
        dat_addr  = daddr;
        dat_write = dwrite;
        e_st = preq && (m_cnt == STARVE_MAX);
        e_pg = preq && (!dreq || e_st);
        e_dg = dreq && !e_pg;
        @(negedge clk);
        chk("prg_grant", 64'(prg_grant), 64'(e_pg));
        chk("dat_grant", 64'(dat_grant), 64'(e_dg));
        chk("starved", 64'(starved), 64'(e_st));
        if (!preq || e_pg) m_cnt = 0;
        else if (m_cnt < STARVE_MAX) m_cnt++;
        if (e_pg) begin
            m_addr = paddr;
            sb.push_back('{1'b1, paddr, cyc + LAT + 1});
        end else if (e_dg) begin
            m_addr  = daddr;
            m_write = dwrite;
            if (!dwe) sb.push_back('{1'b0, daddr, cyc + LAT + 1});
        end
        g_pg = e_pg;
        g_dg = e_dg;
        @(posedge clk);
        #1;
        chk("mem_req", 64'(mem_req), 64'(e_pg | e_dg));
        chk("mem_we", 64'(mem_we), 64'(e_dg & dwe));
        chk("mem_addr", mem_addr, m_addr);
        if (e_dg) chk("mem_write", mem_write, m_write);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        logic          r_preq, r_dreq, r_dwe;
        logic [AW-1:0] r_paddr, r_daddr;
        logic [DW-1:0] r_dwrite;

        prg_req = 1'b0; prg_addr = '0;
        dat_req = 1'b0; dat_we = 1'b0; dat_addr = '0; dat_write = '0;
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_write", mem_write, 64'd0);
        chk("rst_prg_valid", 64'(prg_valid), 64'd0);
        chk("rst_dat_valid", 64'(dat_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // fetch only
        drive(1'b1, 64'h100, 1'b0, 1'b0, '0, '0);
        idle(LAT + 1);

        // contention, then fetch gets through once data drops
        drive(1'b1, 64'h180, 1'b1, 1'b0, 64'h2000, '0);
        drive(1'b1, 64'h180, 1'b0, 1'b0, '0, '0);
        idle(LAT + 1);

        // store: no return of any kind
        drive(1'b0, '0, 1'b1, 1'b1, 64'h40, 64'hDEAD_BEEF);
        idle(LAT + 2);

        // starvation: fetch forced through in cycles 4 and 9
        for (int i = 0; i < 10; i++)
            drive(1'b1, 64'h300, 1'b1, 1'b0, 64'h1000 + 64'(i * 8), '0);
        idle(LAT + 1);

        // reset while a fetch is in flight
        drive(1'b1, 64'h500, 1'b0, 1'b0, '0, '0);
        idle(1);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", 64'(mem_req), 64'd0);
        chk("midrst_prg_valid", 64'(prg_valid), 64'd0);
        sb.delete();
        m_cnt = 0; m_addr = '0; m_write = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(LAT + 2);

        // alternating back-to-back reads
        drive(1'b1, 64'h600, 1'b0, 1'b0, '0, '0);
        drive(1'b0, '0, 1'b1, 1'b0, 64'h2600, '0);
        drive(1'b1, 64'h608, 1'b0, 1'b0, '0, '0);
        idle(LAT + 1);

        // random traffic; denied requesters hold their request stable
        r_preq = 1'b0; r_dreq = 1'b0; r_dwe = 1'b0;
        r_paddr = '0; r_daddr = '0; r_dwrite = '0;
        g_pg = 1'b0; g_dg = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (!(r_preq && !g_pg)) begin
                r_preq  = ($urandom_range(0, 3) != 0);
                r_paddr = {$urandom, $urandom} & ~64'h7;
            end
            if (!(r_dreq && !g_dg)) begin
                r_dreq   = ($urandom_range(0, 2) != 0);
                r_dwe    = ($urandom_range(0, 3) == 0);
                r_daddr  = {$urandom, $urandom} & ~64'h7;
                r_dwrite = {$urandom, $urandom};
            end
            drive(r_preq, r_paddr, r_dreq, r_dwe, r_daddr, r_dwrite);
        end
        idle(LAT + 2);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified fixed-latency memory port between the instruction-fetch requester and the data (load/store) requester of the 64-bit pipeline.
- Grants at most one request per cycle. Data has priority over fetch, with a starvation guard for fetch.
- Tags each issued access and routes the returned word back to the requester that issued it.
- Sits between the PC/ALU stages and external memory; its grant outputs serve as per-requester stall indications.

Parameters:
- LAT, 2, memory read latency in cycles from mem_req cycle to mem_q valid (1..8).
- STARVE_MAX, 4, consecutive denied fetch cycles after which fetch is forced to win (1..15).
- AW, 64, address width.
- DW, 64, data width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- prg_req  in  1  fetch request
- prg_addr  in  AW  fetch address
- prg_grant  out  1  fetch accepted this cycle (combinational)
- prg_q  out  DW  fetch return data
- prg_valid  out  1  prg_q valid
- dat_req  in  1  data request
- dat_we  in  1  1 = store, 0 = load
- dat_addr  in  AW  data address
- dat_write  in  DW  store data
- dat_grant  out  1  data accepted this cycle (combinational)
- dat_q  out  DW  load return data
- dat_valid  out  1  dat_q valid
- mem_req  out  1  memory access issued (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  AW  memory address (registered)
- mem_write  out  DW  memory write data (registered)
- mem_q  in  DW  memory read data, valid LAT cycles after mem_req
- starved  out  1  starvation override active this cycle

Behaviour:
- Reset: all registered outputs are 0 (mem_req, mem_we, mem_addr, mem_write, prg_valid, dat_valid). The starvation counter and in-flight tag pipeline are cleared. rst_n is asynchronous assert, synchronous-safe deassert at the clock edge.
- Arbitration, combinational in cycle N:
  - starved = prg_req & (starve_cnt == STARVE_MAX).
  - prg_grant = prg_req & (~dat_req | starved).
  - dat_grant = dat_req & ~prg_grant.
  - Never both grants high in the same cycle.
- Issue: at the edge ending cycle N, the granted request is registered onto mem_*:
  - mem_req = 1, mem_we = dat_we (data) or 0 (fetch), mem_addr and mem_write = the granted requester's values.
  - With no grant, mem_req = 0 and mem_we = 0; mem_addr and mem_write hold their previous values.
- Starvation counter (4-bit):
  - Increments when prg_req & ~prg_grant, saturating at STARVE_MAX.
  - Clears when prg_grant or ~prg_req.
  - After a forced fetch grant, data wins again on the next contended cycle.
- Return tagging:
  - A LAT-deep shift register carries {valid, is_fetch} from the mem_req cycle.
  - A tag is valid only for reads; stores insert an invalid tag.
  - A tag issued with mem_req in cycle N+1 emerges in cycle N+1+LAT.
  - In that cycle: prg_valid = tag.valid & tag.is_fetch, dat_valid = tag.valid & ~tag.is_fetch.
  - prg_q and dat_q both equal mem_q (combinational pass-through). Consumers qualify them with the valid flags.
- Total read latency from grant cycle N to valid: LAT+1 cycles (3 at default).
- Throughput: one access per cycle sustained; back-to-back reads produce back-to-back valids, in order.
- Requester held off: a requester without a grant keeps its request and its operands stable. The arbiter does not buffer denied requests.
- Request dropped: a requester that drops its request without a grant loses nothing; no side effects.
- Reset mid-flight: all in-flight tags are discarded. No prg_valid or dat_valid is asserted for accesses issued before reset, even though mem_q may still change.
- Store to an address followed by a fetch of the same address: ordering follows grant order; no forwarding.

Test Plan:
- Fetch only: prg_req = 1, prg_addr = 0x100 in cycle 0.
  -> prg_grant = 1 in cycle 0; mem_req = 1, mem_addr = 0x100, mem_we = 0 in cycle 1; prg_valid = 1 with prg_q = mem_q in cycle 3; dat_valid stays 0.
- Contention: prg_req = dat_req = 1, dat_we = 0, dat_addr = 0x2000 in cycle 0.
  -> dat_grant = 1, prg_grant = 0; mem_addr = 0x2000 in cycle 1; dat_valid = 1 in cycle 3.
  -> Fetch is granted in cycle 1 if dat_req drops.
- Store: dat_req = 1, dat_we = 1, dat_addr = 0x40, dat_write = 0xDEADBEEF.
  -> mem_we = 1, mem_write = 0xDEADBEEF next cycle; no prg_valid or dat_valid in any cycle afterward.
- Starvation: dat_req and prg_req held at 1 for 10 cycles (STARVE_MAX = 4).
  -> dat_grant in cycles 0-3; starved = 1 and prg_grant = 1 in cycle 4; dat_grant in cycles 5-8; prg_grant in cycle 9.
- Reset mid-flight: fetch granted in cycle 0; rst_n = 0 in cycle 2 for one cycle.
  -> mem_req = 0 immediately on reset; no prg_valid in cycle 3 or later.
- Alternating reads: fetch read in cycle 0, data read in cycle 1, fetch read in cycle 2, with mem_q = 0xA, 0xB, 0xC in cycles 3-5.
  -> prg_valid with 0xA in cycle 3; dat_valid with 0xB in cycle 4; prg_valid with 0xC in cycle 5.
